fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
Single-clock, parametrised FIFO. It is the synchronous successor to the team's FIFO storage block and adds its own pointer/count management, full/empty/almost flags, and overflow/underflow pulses. Storage and control live in one module. Width and depth are set per instance, and an optional first-word-fall-through (FWFT) read mode is selected at compile time. It sits between producer and consumer logic in the same clock domain, for example a stream buffer ahead of a UART or a DMA engine.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH (derived localparam, 16 by default)
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH (legal range 1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (legal range 0..DEPTH-1)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write word
rd_en  input  1  read (pop) request
rd_data  output  DATA_WIDTH  read word
rd_valid  output  1  rd_data holds a valid popped word (standard mode) or the valid head word (FWFT mode)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  number of stored words, range 0..DEPTH
overflow  output  1  one-cycle pulse on a rejected write
underflow  output  1  one-cycle pulse on a rejected read

Behaviour:
- Reset (rst_n low, asynchronous):
  - Write pointer, read pointer and count clear to 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Flags follow from count = 0: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits. The low bits address memory; the MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- Write acceptance: wr_acc = wr_en && !full, where full is the value registered before the edge. An accepted write stores wr_data at wr_ptr, then wr_ptr increments.
- Read acceptance: rd_acc = rd_en && !empty, with empty taken pre-edge. An accepted read increments rd_ptr.
- Count update per edge:
  - +1 when only the write is accepted.
  - -1 when only the read is accepted.
  - Unchanged when both or neither are accepted.
- Full with wr_en and rd_en together: the read is accepted and the write is rejected. overflow pulses; count drops to DEPTH-1.
- Empty with wr_en and rd_en together: the write is accepted and the read is rejected. underflow pulses; count rises to 1.
- Flags (full, empty, almost_full, almost_empty) are decoded only from the registered count. There is no combinational path from wr_en or rd_en to any flag.
- overflow = 1 for exactly one cycle after an edge where wr_en && full. underflow = 1 for exactly one cycle after an edge where rd_en && empty. Neither is sticky.
- Standard read mode (macro absent):
  - rd_acc at edge N loads rd_data with mem[rd_ptr] and sets rd_valid = 1 after edge N. Read latency is 1 cycle.
  - With no rd_acc, rd_valid = 0 and rd_data holds its last value.
- A written word is readable from the cycle after its write edge; empty deasserts then.
- A reset asserted mid-operation discards all contents immediately, with no drain.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined:
  - rd_data continuously presents mem[rd_ptr] (the head word) whenever !empty, and rd_valid = !empty.
  - rd_en acts as a pop acknowledge: on rd_acc, rd_ptr advances and the next head word appears after the edge.
  - Read latency is 0. A word written at edge N is visible on rd_data after edge N.
  - rd_data is don't-care while empty.
- Undefined: the standard registered-read mode above applies.

Test Plan:
- Reset then idle -> empty = 1, almost_empty = 1, full = 0, count = 0, rd_valid = 0, rd_data = 0.
- Write 0x01..0x10 (16 words) back-to-back -> count = 16, full = 1; almost_full first asserts when count = 12. A 17th write of 0xFF -> overflow pulses for 1 cycle, count stays 16, and the stored data is unchanged.
- From full, read 16 times -> rd_data = 0x01..0x10 in order, each one cycle after its rd_en (standard mode). Then empty = 1; a 17th rd_en -> underflow pulses for 1 cycle and rd_valid = 0.
- Full FIFO, wr_en = rd_en = 1 for 1 cycle -> read of the head word accepted, write rejected, overflow = 1, count = 15. Empty FIFO, wr_en = rd_en = 1 -> write accepted, underflow = 1, count = 1.
- Wrap-around: 40 cycles of simultaneous write/read at a steady count of 5 -> count stays 5, data order preserved across pointer wrap, no overflow or underflow.
- FWFT_EN build: single write of 0xA5 -> rd_data = 0xA5 and rd_valid = 1 the cycle after the write with no rd_en; rd_en = 1 -> empty = 1 and rd_valid = 0 next cycle. Mid-stream rst_n low -> count = 0 asynchronously.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO with count-based flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_V  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_V = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head;

    // Flags decode only from the registered count.
    assign full         = (cnt == DEPTH_V);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AFULL_V);
    assign almost_empty = (cnt <= AEMPTY_V);
    assign count        = cnt;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign head   = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                cnt <= cnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; gated to zero while empty.
    assign rd_data  = empty ? '0 : head;
    assign rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= head;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (default 8x16 configuration).
// Covers standard read mode, or FWFT when FIFO_FWFT_EN is defined.
module tb_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks;
    int failures;

    fifo_sync #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AFULL_THRESH(12),
        .AEMPTY_THRESH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, and sample 1ns after it.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        #12;
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_aempty", {31'b0, almost_empty}, 1);
        check("rst_full", {31'b0, full}, 0);
        check("rst_afull", {31'b0, almost_full}, 0);
        check("rst_count", {27'b0, count}, 0);
        check("rst_rd_valid", {31'b0, rd_valid}, 0);
        check("rst_rd_data", {24'b0, rd_data}, 0);
        check("rst_ovf", {31'b0, overflow}, 0);
        check("rst_udf", {31'b0, underflow}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0);
        check("idle_empty", {31'b0, empty}, 1);

        // Fill with 0x01..0x10; almost_full first at count 12.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            check("fill_count", {27'b0, count}, i + 1);
            check("fill_afull", {31'b0, almost_full}, (i + 1 >= 12) ? 1 : 0);
            check("fill_aempty", {31'b0, almost_empty}, (i + 1 <= 2) ? 1 : 0);
            check("fill_empty", {31'b0, empty}, 0);
        end
        check("full_flag", {31'b0, full}, 1);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_pulse", {31'b0, overflow}, 1);
        check("ovf_count", {27'b0, count}, 16);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_clear", {31'b0, overflow}, 0);

`ifndef FIFO_FWFT_EN
        // Drain in order, one cycle latency.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_valid", {31'b0, rd_valid}, 1);
            check("drain_data", {24'b0, rd_data}, i + 1);
            check("drain_count", {27'b0, count}, 15 - i);
        end
        check("drain_empty", {31'b0, empty}, 1);
        step(1'b0, 8'h00, 1'b1);
        check("udf_pulse", {31'b0, underflow}, 1);
        check("udf_valid", {31'b0, rd_valid}, 0);
        check("udf_hold", {24'b0, rd_data}, 8'h10);
        step(1'b0, 8'h00, 1'b0);
        check("udf_clear", {31'b0, underflow}, 0);

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0);
        end
        check("full2", {31'b0, full}, 1);
        step(1'b1, 8'hEE, 1'b1);
        check("fullrw_ovf", {31'b0, overflow}, 1);
        check("fullrw_count", {27'b0, count}, 15);
        check("fullrw_valid", {31'b0, rd_valid}, 1);
        check("fullrw_data", {24'b0, rd_data}, 8'h20);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("fullrw_drain", {24'b0, rd_data}, 8'h20 + i);
        end
        check("fullrw_empty", {31'b0, empty}, 1);

        // Empty with simultaneous write and read.
        step(1'b1, 8'h77, 1'b1);
        check("emptyrw_udf", {31'b0, underflow}, 1);
        check("emptyrw_count", {27'b0, count}, 1);
        check("emptyrw_valid", {31'b0, rd_valid}, 0);
        step(1'b0, 8'h00, 1'b1);
        check("emptyrw_data", {24'b0, rd_data}, 8'h77);
        check("emptyrw_cnt0", {27'b0, count}, 0);

        // Steady-state streaming at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h45 + i), 1'b1);
            check("wrap_count", {27'b0, count}, 5);
            check("wrap_data", {24'b0, rd_data}, 8'(8'h40 + i));
            check("wrap_flags", {30'b0, overflow, underflow}, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("wrap_tail", {24'b0, rd_data}, 8'(8'h40 + 40 + i));
        end
        check("wrap_empty", {31'b0, empty}, 1);
`else
        // FWFT: head visible without rd_en, pop via rd_en.
        check("fwft_head", {24'b0, rd_data}, 8'h01);
        check("fwft_full_valid", {31'b0, rd_valid}, 1);
        for (int i = 0; i < 16; i++) begin
            check("fwft_drain", {24'b0, rd_data}, i + 1);
            step(1'b0, 8'h00, 1'b1);
        end
        check("fwft_drained", {31'b0, empty}, 1);
        step(1'b1, 8'hA5, 1'b0);
        check("fwft_a5", {24'b0, rd_data}, 8'hA5);
        check("fwft_a5_valid", {31'b0, rd_valid}, 1);
        step(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", {31'b0, empty}, 1);
        check("fwft_pop_valid", {31'b0, rd_valid}, 0);
`endif

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h90 + i), 1'b0);
        end
        check("pre_rst_count", {27'b0, count}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", {27'b0, count}, 0);
        check("async_rst_empty", {31'b0, empty}, 1);
        check("async_rst_valid", {31'b0, rd_valid}, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_udf", {31'b0, underflow}, 1);
        check("post_rst_count", {27'b0, count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
